// File: rtl/ibex_pkg.sv
// Shared FPU types.
// Operand classes seen by the bfloat16-to-integer converter.
package ibex_pkg;

    typedef enum logic [2:0] {
        Normal   = 3'd0,
        Sub_Norm = 3'd1,
        Inf      = 3'd2,
        Neg_Inf  = 3'd3,
        NaN      = 3'd4
    } Classif_e;

endpackage

// File: rtl/fp_cvt_seq.sv
// Request/response sequencer around the combinational bf16-to-int converter.
// Registers and classifies the operand, holds the converter inputs for a cycle.
module fp_cvt_seq
    import ibex_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [15:0]      req_fp_i,
    input  logic             req_mode_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_int_o,
    output logic [2:0]       resp_flag_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic [15:0]      cvt_fp_o,
    output logic             cvt_mode_o,
    output Classif_e         cvt_classif_o,
    input  logic [31:0]      cvt_int_i,
    input  logic [2:0]       cvt_flag_i,
    input  logic             flush_i,
    input  logic             fflags_clr_i,
    output logic [2:0]       fflags_o,
    output logic             busy_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLASS = 2'd1;
    localparam logic [1:0] CONV  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [15:0]      fp_q, fp_d;
    logic             mode_q, mode_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    Classif_e         cls_q, cls_d;
    logic [31:0]      res_q, res_d;
    logic [2:0]       flag_q, flag_d;
    logic [2:0]       fflags_q, fflags_d;

    logic     exp_max, exp_zero, man_nz, resp_hs;
    Classif_e cls_new;

    assign exp_max  = &fp_q[14:7];
    assign exp_zero = ~|fp_q[14:7];
    assign man_nz   = |fp_q[6:0];

    always_comb begin
        cls_new = Normal;
        unique case (1'b1)
            exp_max && man_nz:                cls_new = NaN;
            exp_max && !man_nz && !fp_q[15]: cls_new = Inf;
            exp_max && !man_nz && fp_q[15]:  cls_new = Neg_Inf;
            exp_zero && man_nz:               cls_new = Sub_Norm;
            default:                          cls_new = Normal;
        endcase
    end

    // A flush beats the response handshake, so it never touches fflags.
    assign resp_hs = (state_q == RESP) && resp_ready_i && !flush_i;

    always_comb begin
        state_d = state_q;
        fp_d    = fp_q;
        mode_d  = mode_q;
        tag_d   = tag_q;
        cls_d   = cls_q;
        res_d   = res_q;
        flag_d  = flag_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    fp_d    = req_fp_i;
                    mode_d  = req_mode_i;
                    tag_d   = req_tag_i;
                    state_d = CLASS;
                end
            end
            CLASS: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (exp_zero && !man_nz) begin
                    res_d   = '0;
                    flag_d  = '0;
                    state_d = RESP;
                end else begin
                    cls_d   = cls_new;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    res_d   = cvt_int_i;
                    flag_d  = cvt_flag_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (flush_i || resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fflags_d = fflags_clr_i ? 3'b000 : fflags_q;
        if (resp_hs) begin
            fflags_d = fflags_d | flag_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            fp_q     <= '0;
            mode_q   <= 1'b0;
            tag_q    <= '0;
            cls_q    <= Normal;
            res_q    <= '0;
            flag_q   <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            fp_q     <= fp_d;
            mode_q   <= mode_d;
            tag_q    <= tag_d;
            cls_q    <= cls_d;
            res_q    <= res_d;
            flag_q   <= flag_d;
            fflags_q <= fflags_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign resp_valid_o  = (state_q == RESP);
    assign resp_int_o    = res_q;
    assign resp_flag_o   = flag_q;
    assign resp_tag_o    = tag_q;
    assign cvt_fp_o      = fp_q;
    assign cvt_mode_o    = mode_q;
    assign cvt_classif_o = cls_q;
    assign fflags_o      = fflags_q;

endmodule

// File: tb/tb_fp_cvt_seq.sv
// Bench for fp_cvt_seq: behavioural converter plus a transaction-level model
// of the sequencer, checked every cycle, with directed cases pinning both.
module tb_fp_cvt_seq;
    import ibex_pkg::*;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready_o;
    logic [15:0]      req_fp = '0;
    logic             req_mode = 1'b0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             resp_valid_o;
    logic             resp_ready = 1'b0;
    logic [31:0]      resp_int_o;
    logic [2:0]       resp_flag_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic [15:0]      cvt_fp_o;
    logic             cvt_mode_o;
    Classif_e         cvt_classif_o;
    logic [31:0]      cvt_int_i;
    logic [2:0]       cvt_flag_i;
    logic             flush = 1'b0;
    logic             fflags_clr = 1'b0;
    logic [2:0]       fflags_o;
    logic             busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp_cvt_seq #(.TAG_W(TAG_W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_fp_i      (req_fp),
        .req_mode_i    (req_mode),
        .req_tag_i     (req_tag),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready),
        .resp_int_o    (resp_int_o),
        .resp_flag_o   (resp_flag_o),
        .resp_tag_o    (resp_tag_o),
        .cvt_fp_o      (cvt_fp_o),
        .cvt_mode_o    (cvt_mode_o),
        .cvt_classif_o (cvt_classif_o),
        .cvt_int_i     (cvt_int_i),
        .cvt_flag_i    (cvt_flag_i),
        .flush_i       (flush),
        .fflags_clr_i  (fflags_clr),
        .fflags_o      (fflags_o),
        .busy_o        (busy_o)
    );

    // Value-level bf16 -> int32/uint32, round half up, saturating.
    function automatic logic [34:0] conv_fn(input logic [15:0] fp, input logic md);
        int  e;
        int  m;
        real v;
        real rv;
        logic [31:0] r;
        logic [2:0]  f;
        e = int'(fp[14:7]);
        m = int'(fp[6:0]);
        r = '0;
        f = 3'b000;
        if (e == 255) begin
            f = 3'b001;
            if (m != 0 || !fp[15]) r = md ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            else                   r = md ? 32'h0 : 32'h8000_0000;
        end else if (e == 0) begin
            f = (m != 0) ? 3'b010 : 3'b000;
        end else begin
            v = real'(128 + m) * $pow(2.0, real'(e) - 134.0);
            if (fp[15]) v = -v;
            rv = $floor(v + 0.5);
            if (md && rv > 4294967295.0) begin
                r = 32'hFFFF_FFFF; f = 3'b001;
            end else if (md && rv < 0.0) begin
                r = 32'h0; f = 3'b001;
            end else if (!md && rv > 2147483647.0) begin
                r = 32'h7FFF_FFFF; f = 3'b001;
            end else if (!md && rv < -2147483648.0) begin
                r = 32'h8000_0000; f = 3'b001;
            end else begin
                r = 32'(longint'(rv));
                f = (rv == 0.0) ? 3'b010 : 3'b000;
            end
        end
        return {f, r};
    endfunction

    function automatic Classif_e class_fn(input logic [15:0] fp);
        if (fp[14:7] == 8'hFF && fp[6:0] != 0) return NaN;
        if (fp[14:7] == 8'hFF) return fp[15] ? Neg_Inf : Inf;
        if (fp[14:7] == 8'h00 && fp[6:0] != 0) return Sub_Norm;
        return Normal;
    endfunction

    assign {cvt_flag_i, cvt_int_i} = conv_fn(cvt_fp_o, cvt_mode_o);

    // Model: one conversion in flight, aged in cycles since acceptance.
    bit               m_busy;
    int               m_age;
    logic [15:0]      m_fp;
    logic             m_mode;
    logic [TAG_W-1:0] m_tag;
    logic [2:0]       m_ff;
    int               m_lat;
    logic [34:0]      m_exp;
    bit               e_valid, e_conv, m_hs;

    assign m_lat   = (m_fp[14:0] == 0) ? 1 : 2;
    assign m_exp   = (m_fp[14:0] == 0) ? 35'd0 : conv_fn(m_fp, m_mode);
    assign e_valid = m_busy && (m_age >= m_lat);
    assign e_conv  = m_busy && (m_lat == 2) && (m_age == 1);
    assign m_hs    = e_valid && resp_ready && !flush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_fp   <= '0;
            m_mode <= 1'b0;
            m_tag  <= '0;
            m_ff   <= '0;
        end else begin
            m_ff <= (fflags_clr ? 3'b000 : m_ff) | (m_hs ? m_exp[34:32] : 3'b000);
            if (!m_busy) begin
                if (req_valid && !flush) begin
                    m_busy <= 1'b1;
                    m_age  <= 0;
                    m_fp   <= req_fp;
                    m_mode <= req_mode;
                    m_tag  <= req_tag;
                end
            end else if (flush || m_hs) begin
                m_busy <= 1'b0;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("req_ready", 32'(req_ready_o), 32'(!m_busy));
        check("busy", 32'(busy_o), 32'(m_busy));
        check("resp_valid", 32'(resp_valid_o), 32'(e_valid));
        check("fflags", 32'(fflags_o), 32'(m_ff));
        if (e_valid) begin
            check("resp_int", resp_int_o, m_exp[31:0]);
            check("resp_flag", 32'(resp_flag_o), 32'(m_exp[34:32]));
            check("resp_tag", 32'(resp_tag_o), 32'(m_tag));
        end
        if (e_conv) begin
            check("cvt_fp", 32'(cvt_fp_o), 32'(m_fp));
            check("cvt_mode", 32'(cvt_mode_o), 32'(m_mode));
            check("cvt_class", 32'(cvt_classif_o), 32'(class_fn(m_fp)));
        end
    end

    task automatic send(input logic [15:0] fp, input logic md, input logic [TAG_W-1:0] tg);
        int n;
        n = 0;
        req_fp = fp; req_mode = md; req_tag = tg; req_valid = 1'b1;
        while (!req_ready_o && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("req_accept", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic recv(input logic [31:0] ei, input logic [2:0] ef, input logic [TAG_W-1:0] et,
                        input int lat, input Classif_e ec, input int hold, input logic clr);
        int n;
        n = 0;
        while (!resp_valid_o && n < 10) begin
            if (n == 1 && lat == 2) check("lit_class", 32'(cvt_classif_o), 32'(ec));
            @(posedge clk); #1; n++;
        end
        check("lit_latency", 32'(n), 32'(lat));
        check("lit_int", resp_int_o, ei);
        check("lit_flag", 32'(resp_flag_o), 32'(ef));
        check("lit_tag", 32'(resp_tag_o), 32'(et));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("lit_hold_valid", 32'(resp_valid_o), 32'd1);
            check("lit_hold_int", resp_int_o, ei);
            check("lit_hold_tag", 32'(resp_tag_o), 32'(et));
            check("lit_hold_ready", 32'(req_ready_o), 32'd0);
        end
        resp_ready = 1'b1; fflags_clr = clr;
        @(posedge clk); #1;
        resp_ready = 1'b0; fflags_clr = 1'b0;
        check("lit_idle", 32'(busy_o), 32'd0);
    endtask

    function automatic logic [15:0] rand_fp();
        logic       s;
        logic [6:0] mz;
        s  = 1'($urandom);
        mz = 7'($urandom_range(1, 127));
        case ($urandom_range(0, 5))
            0:       return {s, 15'h0};
            1:       return {s, 8'hFF, 7'h0};
            2:       return {s, 8'hFF, mz};
            3:       return {s, 8'h00, mz};
            default: return {s, 8'($urandom_range(100, 170)), 7'($urandom)};
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(resp_valid_o), 32'd0);
        check("rst_fflags", 32'(fflags_o), 32'd0);
        check("rst_int", resp_int_o, 32'd0);
        check("rst_tag", 32'(resp_tag_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(16'h3F80, 1'b0, 4'd3);
        recv(32'd1, 3'b000, 4'd3, 2, Normal, 0, 1'b0);
        check("lit_ff_a", 32'(fflags_o), 32'd0);

        send(16'h4020, 1'b1, 4'd5);
        recv(32'd3, 3'b000, 4'd5, 2, Normal, 0, 1'b0);

        send(16'h7F80, 1'b0, 4'd6);
        recv(32'h7FFF_FFFF, 3'b001, 4'd6, 2, Inf, 0, 1'b0);
        check("lit_ff_b", 32'(fflags_o), 32'd1);
        send(16'h0001, 1'b1, 4'd7);
        recv(32'd0, 3'b010, 4'd7, 2, Sub_Norm, 0, 1'b0);
        check("lit_ff_c", 32'(fflags_o), 32'd3);

        send(16'h0000, 1'b0, 4'd9);
        recv(32'd0, 3'b000, 4'd9, 1, Normal, 5, 1'b0);
        check("lit_ff_d", 32'(fflags_o), 32'd3);

        send(16'h7F80, 1'b0, 4'd2);
        @(posedge clk); #1;
        check("lit_flush_class", 32'(cvt_classif_o), 32'(Inf));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("lit_flush_busy", 32'(busy_o), 32'd0);
        check("lit_flush_valid", 32'(resp_valid_o), 32'd0);
        check("lit_flush_ff", 32'(fflags_o), 32'd3);
        check("lit_flush_ready", 32'(req_ready_o), 32'd1);
        send(16'h3F80, 1'b0, 4'd4);
        recv(32'd1, 3'b000, 4'd4, 2, Normal, 0, 1'b0);

        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        check("lit_clr_a", 32'(fflags_o), 32'd0);
        send(16'h7F80, 1'b0, 4'd8);
        recv(32'h7FFF_FFFF, 3'b001, 4'd8, 2, Inf, 0, 1'b0);
        check("lit_ff_e", 32'(fflags_o), 32'd1);
        send(16'h7FC0, 1'b0, 4'd1);
        recv(32'h7FFF_FFFF, 3'b001, 4'd1, 2, NaN, 0, 1'b1);
        check("lit_clr_hs", 32'(fflags_o), 32'd1);
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        check("lit_clr_b", 32'(fflags_o), 32'd0);

        send(16'h4020, 1'b0, 4'd3);
        rst_n = 1'b0;
        #1;
        check("lit_mid_rst_busy", 32'(busy_o), 32'd0);
        check("lit_mid_rst_valid", 32'(resp_valid_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            req_valid  = ($urandom_range(0, 1) == 1);
            req_fp     = rand_fp();
            req_mode   = 1'($urandom);
            req_tag    = TAG_W'($urandom);
            resp_ready = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 19) == 0);
            fflags_clr = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0; flush = 1'b0; fflags_clr = 1'b0; resp_ready = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
